// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, default widths and the arbiter state type.
package alu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int OPC_W_DEF  = 4;

  localparam logic [OPC_W_DEF-1:0] OPC_ADD  = 4'b0000;
  localparam logic [OPC_W_DEF-1:0] OPC_SLL  = 4'b0001;
  localparam logic [OPC_W_DEF-1:0] OPC_SLT  = 4'b0010;
  localparam logic [OPC_W_DEF-1:0] OPC_SLTU = 4'b0011;
  localparam logic [OPC_W_DEF-1:0] OPC_XOR  = 4'b0100;
  localparam logic [OPC_W_DEF-1:0] OPC_SRL  = 4'b0101;
  localparam logic [OPC_W_DEF-1:0] OPC_OR   = 4'b0110;
  localparam logic [OPC_W_DEF-1:0] OPC_AND  = 4'b0111;
  localparam logic [OPC_W_DEF-1:0] OPC_SUB  = 4'b1000;
  localparam logic [OPC_W_DEF-1:0] OPC_SRA  = 4'b1101;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

endpackage

// File: rtl/alu_share_arbiter_alu_unit.sv
// Combinational integer ALU. Shift amounts are the full op2 value, so shifts of 32 or more
// flush to zero (logical) or to the sign (arithmetic); undefined opcodes yield zero.
module ALU_unit
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OPC_W  = OPC_W_DEF
) (
  input  logic [DATA_W-1:0] i_op1,
  input  logic [DATA_W-1:0] i_op2,
  input  logic [OPC_W-1:0]  i_opcode,
  output logic [DATA_W-1:0] o_result
);

  always_comb begin
    o_result = '0;
    case (i_opcode)
      OPC_ADD:  o_result = i_op1 + i_op2;
      OPC_SLL:  o_result = i_op1 << i_op2;
      OPC_SLT:  o_result = {{(DATA_W-1){1'b0}}, ($signed(i_op1) < $signed(i_op2))};
      OPC_SLTU: o_result = {{(DATA_W-1){1'b0}}, (i_op1 < i_op2)};
      OPC_XOR:  o_result = i_op1 ^ i_op2;
      OPC_SRL:  o_result = i_op1 >> i_op2;
      OPC_OR:   o_result = i_op1 | i_op2;
      OPC_AND:  o_result = i_op1 & i_op2;
      OPC_SUB:  o_result = i_op1 - i_op2;
      OPC_SRA:  o_result = $unsigned($signed(i_op1) >>> i_op2);
      default:  o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; one result outstanding at a
// time, returned registered on the owner's response channel.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OPC_W  = OPC_W_DEF
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              req0_valid_in,
  output logic              req0_ready_out,
  input  logic [DATA_W-1:0] req0_op1_in,
  input  logic [DATA_W-1:0] req0_op2_in,
  input  logic [OPC_W-1:0]  req0_opcode_in,
  input  logic              req1_valid_in,
  output logic              req1_ready_out,
  input  logic [DATA_W-1:0] req1_op1_in,
  input  logic [DATA_W-1:0] req1_op2_in,
  input  logic [OPC_W-1:0]  req1_opcode_in,
  output logic              rsp0_valid_out,
  input  logic              rsp0_ready_in,
  output logic [DATA_W-1:0] rsp0_result_out,
  output logic              rsp1_valid_out,
  input  logic              rsp1_ready_in,
  output logic [DATA_W-1:0] rsp1_result_out,
  output logic              busy_out
);

  // Handshakes: a transfer happens on a channel in a cycle where valid and ready are both
  // high; valid never waits on ready, and the sender holds its payload while valid & !ready.

  state_e              r_state;
  state_e              w_state_nxt;
  logic                r_owner;
  logic                r_last_grant;
  logic [DATA_W-1:0]   r_result;

  logic                w_rsp_fire;
  logic                w_free;
  logic                w_grant;
  logic                w_grant_vld;
  logic                w_accept;
  logic [DATA_W-1:0]   w_op1;
  logic [DATA_W-1:0]   w_op2;
  logic [OPC_W-1:0]    w_opcode;
  logic [DATA_W-1:0]   w_alu_result;

  // The slot frees in the same cycle the owner drains it, allowing one op per cycle.
  assign w_rsp_fire = (r_state == RESP) && (r_owner ? rsp1_ready_in : rsp0_ready_in);
  assign w_free     = (r_state == IDLE) || w_rsp_fire;

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = 1'b0;
    if (w_free) begin
      if (req0_valid_in && req1_valid_in) begin
        w_grant_vld = 1'b1;
        w_grant     = ~r_last_grant;
      end else if (req0_valid_in) begin
        w_grant_vld = 1'b1;
        w_grant     = 1'b0;
      end else if (req1_valid_in) begin
        w_grant_vld = 1'b1;
        w_grant     = 1'b1;
      end
    end
  end

  assign w_accept       = w_grant_vld;
  assign req0_ready_out = w_grant_vld && !w_grant;
  assign req1_ready_out = w_grant_vld && w_grant;

  assign w_op1    = w_grant ? req1_op1_in    : req0_op1_in;
  assign w_op2    = w_grant ? req1_op2_in    : req0_op2_in;
  assign w_opcode = w_grant ? req1_opcode_in : req0_opcode_in;

  ALU_unit #(
    .DATA_W (DATA_W),
    .OPC_W  (OPC_W)
  ) u_alu (
    .i_op1    (w_op1),
    .i_op2    (w_op2),
    .i_opcode (w_opcode),
    .o_result (w_alu_result)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = RESP;
      RESP: begin
        if (w_accept)        w_state_nxt = RESP;
        else if (w_rsp_fire) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  // Last grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_result     <= '0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_result     <= w_alu_result;
      r_owner      <= w_grant;
      r_last_grant <= w_grant;
    end
  end

  assign rsp0_valid_out  = (r_state == RESP) && !r_owner;
  assign rsp1_valid_out  = (r_state == RESP) && r_owner;
  assign rsp0_result_out = r_result;
  assign rsp1_result_out = r_result;
  assign busy_out        = (r_state == RESP);

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-requester arbiter and sequencer for the shared 32-bit integer ALU. Accepts operations from requester 0 (execute stage) and requester 1 (address/auxiliary unit) over valid/ready handshakes, grants the single ALU round-robin, registers the result, and returns it on the owning requester's response channel. At most one operation is outstanding.

## Interface
- DATA_W, 32, operand and result width
- OPC_W, 4, ALU opcode width (encoding in shared package)

- clk_in  input  1  clock; all state updates on rising edge
- rst_n_in  input  1  reset, asynchronous, active-low
- req0_valid_in / req1_valid_in  input  1  requester i presents an operation
- req0_ready_out / req1_ready_out  output  1  requester i operation accepted this cycle when valid&ready
- req0_op1_in / req1_op1_in  input  DATA_W  operand 1
- req0_op2_in / req1_op2_in  input  DATA_W  operand 2
- req0_opcode_in / req1_opcode_in  input  OPC_W  ALU opcode
- rsp0_valid_out / rsp1_valid_out  output  1  result pending for requester i
- rsp0_ready_in / rsp1_ready_in  input  1  requester i takes result
- rsp0_result_out / rsp1_result_out  output  DATA_W  registered result; both outputs carry the same registered value
- busy_out  output  1  a result is pending (state RESP)

## Operation
- States: IDLE (no result pending), RESP (result_q held for owner_q).
- free = (state==IDLE) | (state==RESP & rsp_valid[owner_q] & rsp_ready[owner_q]).
- Grant when free: one valid -> that requester; both valid -> requester != last_grant_q; none -> no grant.
- reqi_ready_out = free & grant==i; combinational, never asserted for a non-granted requester; may depend on rspX_ready_in.
- Accept (valid&ready for i): ALU evaluates op1/op2/opcode of i this cycle; result_q <= ALU result, owner_q <= i, last_grant_q <= i, state -> RESP.
- RESP with owner's response accepted and no new accept: state -> IDLE; result_q retains its value.
- RESP with owner not ready: state, result_q, owner_q held; both req ready low.
- rspi_valid_out = (state==RESP) & owner_q==i; the other requester's rsp_valid is 0.
- ALU semantics unchanged: add, sll, slt, sltu, xor, srl, or, and, sub, sra; undefined opcode -> result 0; shift amounts passed unmasked (op2 ≥ 32 per ALU behaviour).
- last_grant_q updated only on accept; the round-robin pointer does not move on idle cycles.
- Requester holds op/opcode stable while valid & !ready; arbiter does not sample them otherwise.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, result_q=0, owner_q=0, last_grant_q=1 (requester 0 wins first tie), all rsp_valid_out=0, busy_out=0, rsp_result_out=0.
- Latency: accept in cycle N -> rsp_valid_out high in N+1.
- Throughput: 1 op/cycle when the owner's rsp_ready_in is high every cycle; response accept and new request accept in the same cycle are legal.
- Reset mid-RESP: pending result discarded, no response delivered.
- Tie with a back-to-back accept: the same requester is never granted twice in a row while the other is valid.

## Structure
- Shared package alu_pkg: ALU opcode constants (ADD=0000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100, SRL=0101, OR=0110, AND=0111, SUB=1000, SRA=1101), DATA_W/OPC_W defaults, state enum {IDLE, RESP}.
- One sub-module: a single instance of ALU_unit fed by the granted requester's operand mux; arbitration and handshake logic live in alu_share_arbiter.

## Test plan
- Reset, then req0 valid ADD 5+7 alone -> req0_ready high same cycle, next cycle rsp0_valid=1, result 12, rsp1_valid=0.
- Both valid after reset (req0 SUB 10-3, req1 XOR F0^0F) with rsp ready high -> req0 granted first (result 7), req1 next cycle (result FF), alternation continues under sustained contention.
- rsp0_ready low 3 cycles with req1 valid -> busy_out high, req1_ready low, result_q stable; on rsp0_ready, req1 accepted same cycle, result next cycle.
- Undefined opcode 1111 and SLL 1<<4 -> results 0 and 16.
- Assert rst_n_in low while in RESP -> all rsp_valid_out drop immediately, result 0; after release req1-only op served normally.
